// File: rtl/actuador_expendedora.sv
// Actuator sequencer for the vending machine: queues dispense and coin
// requests and replays them as timed solenoid / coin-ejector pulses.
module actuador_expendedora #(
  parameter int PULSO_CICLOS = 4,
  parameter int PAUSA_CICLOS = 2,
  parameter int ANCHO_CNT    = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       expulsar,
  input  logic [1:0] cambio,
  output logic       solenoide_producto,
  output logic       expulsor_moneda,
  output logic       ocupado,
  output logic       desborde
);

  localparam int TMAX = (PULSO_CICLOS > PAUSA_CICLOS) ? PULSO_CICLOS : PAUSA_CICLOS;
  localparam int TW   = $clog2(TMAX) + 1;
  localparam int CW   = ANCHO_CNT + 2;
  localparam logic [CW-1:0] MAXC = CW'((2 ** ANCHO_CNT) - 1);

  typedef enum logic [1:0] {
    REPOSO,
    PRODUCTO,
    MONEDA,
    PAUSA
  } estado_t;

  estado_t              estado_q, estado_d;
  logic [TW-1:0]        timer_q, timer_d;
  logic [ANCHO_CNT-1:0] pend_prod_q, pend_prod_d;
  logic [ANCHO_CNT-1:0] pend_mon_q, pend_mon_d;
  logic                 exp_q;
  logic [1:0]           cam_q;
  logic                 sol_q, sol_d;
  logic                 mon_q, mon_d;
  logic                 desb_q, desb_d;

  logic          ev_p, ev_m;
  logic          deq_p, deq_m, arrancar;
  logic [CW-1:0] suma_p, suma_m;

  assign ev_p = expulsar & ~exp_q;
  assign ev_m = (cambio != 2'b00) & (cambio != cam_q);

  always_comb begin
    estado_d = estado_q;
    timer_d  = timer_q + TW'(1);
    sol_d    = sol_q;
    mon_d    = mon_q;
    deq_p    = 1'b0;
    deq_m    = 1'b0;
    arrancar = 1'b0;
    unique case (estado_q)
      REPOSO: begin
        timer_d  = '0;
        arrancar = 1'b1;
      end
      PRODUCTO, MONEDA: begin
        if (timer_q == TW'(PULSO_CICLOS - 1)) begin
          estado_d = PAUSA;
          timer_d  = '0;
          sol_d    = 1'b0;
          mon_d    = 1'b0;
        end
      end
      PAUSA: begin
        if (timer_q == TW'(PAUSA_CICLOS - 1)) begin
          estado_d = REPOSO;
          timer_d  = '0;
          arrancar = 1'b1;
        end
      end
      default: begin
        estado_d = REPOSO;
        timer_d  = '0;
      end
    endcase
    // The edge closing the pause doubles as the first idle cycle.
    if (arrancar) begin
      if (pend_prod_q != '0) begin
        estado_d = PRODUCTO;
        timer_d  = '0;
        sol_d    = 1'b1;
        deq_p    = 1'b1;
      end else if (pend_mon_q != '0) begin
        estado_d = MONEDA;
        timer_d  = '0;
        mon_d    = 1'b1;
        deq_m    = 1'b1;
      end
    end
  end

  always_comb begin
    suma_p = CW'(pend_prod_q) + CW'(ev_p) - CW'(deq_p);
    suma_m = CW'(pend_mon_q) + (ev_m ? CW'(cambio) : '0) - CW'(deq_m);
    pend_prod_d = (suma_p > MAXC) ? '1 : suma_p[ANCHO_CNT-1:0];
    pend_mon_d  = (suma_m > MAXC) ? '1 : suma_m[ANCHO_CNT-1:0];
    desb_d = desb_q | (suma_p > MAXC) | (suma_m > MAXC);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      estado_q    <= REPOSO;
      timer_q     <= '0;
      pend_prod_q <= '0;
      pend_mon_q  <= '0;
      exp_q       <= 1'b0;
      cam_q       <= 2'b00;
      sol_q       <= 1'b0;
      mon_q       <= 1'b0;
      desb_q      <= 1'b0;
    end else begin
      estado_q    <= estado_d;
      timer_q     <= timer_d;
      pend_prod_q <= pend_prod_d;
      pend_mon_q  <= pend_mon_d;
      exp_q       <= expulsar;
      cam_q       <= cambio;
      sol_q       <= sol_d;
      mon_q       <= mon_d;
      desb_q      <= desb_d;
    end
  end

  assign solenoide_producto = sol_q;
  assign expulsor_moneda    = mon_q;
  assign desborde           = desb_q;
  assign ocupado = (estado_q != REPOSO) | (pend_prod_q != '0) | (pend_mon_q != '0);

endmodule

// File: tb/tb_actuador_expendedora.sv
// Randomized + directed bench for actuador_expendedora against a
// window-based model of the pulse/pause schedule.
module tb_actuador_expendedora;

  localparam int PULSO = 4;
  localparam int PAUSA = 2;
  localparam int ANCHO = 4;
  localparam int MAXP  = (1 << ANCHO) - 1;
  localparam int VENT  = PULSO + PAUSA;

  logic       clk = 1'b0;
  logic       rst;
  logic       expulsar;
  logic [1:0] cambio;
  logic       sol, mon, ocu, desb;

  actuador_expendedora #(
    .PULSO_CICLOS(PULSO),
    .PAUSA_CICLOS(PAUSA),
    .ANCHO_CNT(ANCHO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .expulsar(expulsar),
    .cambio(cambio),
    .solenoide_producto(sol),
    .expulsor_moneda(mon),
    .ocupado(ocu),
    .desborde(desb)
  );

  always #5 clk = ~clk;

  // Model: pending counts plus the remaining cycles of the current
  // pulse+pause window (0 = free to start the next request).
  int   m_pp, m_pm, m_left;
  bit   m_prod, m_ovf;
  logic m_pe;
  logic [1:0] m_pc;
  int   m_inc, m_dp, m_dm, m_sum;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_pp = 0; m_pm = 0; m_left = 0; m_prod = 0; m_ovf = 0;
      m_pe = 0; m_pc = 2'b00;
    end else begin
      m_dp = 0;
      m_dm = 0;
      m_inc = (cambio != 2'b00 && cambio != m_pc) ? int'(cambio) : 0;
      if (m_left > 0) m_left = m_left - 1;
      if (m_left == 0) begin
        if (m_pp > 0) begin
          m_dp = 1; m_left = VENT; m_prod = 1;
        end else if (m_pm > 0) begin
          m_dm = 1; m_left = VENT; m_prod = 0;
        end
      end
      m_sum = m_pp + ((expulsar && !m_pe) ? 1 : 0) - m_dp;
      if (m_sum > MAXP) begin m_sum = MAXP; m_ovf = 1; end
      m_pp = m_sum;
      m_sum = m_pm + m_inc - m_dm;
      if (m_sum > MAXP) begin m_sum = MAXP; m_ovf = 1; end
      m_pm = m_sum;
      m_pe = expulsar;
      m_pc = cambio;
    end
  end

  function automatic bit exp_sol();
    return m_left > PAUSA && m_prod;
  endfunction
  function automatic bit exp_mon();
    return m_left > PAUSA && !m_prod;
  endfunction
  function automatic bit exp_ocu();
    return m_left > 0 || m_pp > 0 || m_pm > 0;
  endfunction

  int n_tot_m = 0, n_pass_m = 0;
  int n_tot_l = 0, n_pass_l = 0;
  bit chk_en = 0;

  task automatic mcheck(input string nm, input int act, input int req);
    n_tot_m++;
    if (act == req) n_pass_m++;
    else $display("FAIL %s t=%0t actual=%0d required=%0d", nm, $time, act, req);
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      mcheck("model_sol", int'(sol), int'(exp_sol()));
      mcheck("model_mon", int'(mon), int'(exp_mon()));
      mcheck("model_ocu", int'(ocu), int'(exp_ocu()));
      mcheck("model_desb", int'(desb), int'(m_ovf));
      if (sol && mon) mcheck("both_high", 1, 0);
    end
  end

  int   cnt_sol = 0, cnt_mon = 0;
  logic sol_p = 0, mon_p = 0;
  always @(negedge clk) begin
    if (sol && !sol_p) cnt_sol++;
    if (mon && !mon_p) cnt_mon++;
    sol_p = sol;
    mon_p = mon;
  end

  task automatic lcheck(input string nm, input int act, input int req);
    n_tot_l++;
    if (act == req) n_pass_l++;
    else $display("FAIL %s t=%0t actual=%0d required=%0d", nm, $time, act, req);
  endtask

  task automatic wait_idle(input int bound);
    bit done = 0;
    for (int i = 0; i < bound && !done; i++) begin
      @(negedge clk);
      if (!ocu && !exp_ocu()) done = 1;
    end
    lcheck("idle_within_bound", int'(done), 1);
  endtask

  int b_sol, b_mon;

  initial begin
    rst = 1'b0;
    expulsar = 1'b0;
    cambio = 2'b00;
    repeat (2) @(negedge clk);
    lcheck("rst_sol", int'(sol), 0);
    lcheck("rst_mon", int'(mon), 0);
    lcheck("rst_ocu", int'(ocu), 0);
    lcheck("rst_desb", int'(desb), 0);
    rst = 1'b1;
    chk_en = 1;
    repeat (2) @(negedge clk);

    // Single dispense: 4 high, 2 pause, then idle.
    b_mon = cnt_mon;
    expulsar = 1'b1;
    @(negedge clk);
    expulsar = 1'b0;
    lcheck("t1_ocu_j0", int'(ocu), 1);
    lcheck("t1_sol_j0", int'(sol), 0);
    for (int j = 1; j <= 8; j++) begin
      @(negedge clk);
      lcheck($sformatf("t1_sol_j%0d", j), int'(sol), int'(j >= 1 && j <= 4));
      lcheck($sformatf("t1_ocu_j%0d", j), int'(ocu), int'(j <= 6));
    end
    lcheck("t1_no_coin", cnt_mon - b_mon, 0);

    // Product and one coin together: product first.
    expulsar = 1'b1;
    cambio = 2'b01;
    @(negedge clk);
    expulsar = 1'b0;
    cambio = 2'b00;
    for (int j = 1; j <= 13; j++) begin
      @(negedge clk);
      lcheck($sformatf("t2_sol_j%0d", j), int'(sol), int'(j >= 1 && j <= 4));
      lcheck($sformatf("t2_mon_j%0d", j), int'(mon), int'(j >= 7 && j <= 10));
      lcheck($sformatf("t2_ocu_j%0d", j), int'(ocu), int'(j <= 12));
    end

    // Two coins: two pulses separated by exactly two low cycles.
    cambio = 2'b10;
    @(negedge clk);
    cambio = 2'b00;
    for (int j = 1; j <= 13; j++) begin
      @(negedge clk);
      lcheck($sformatf("t3_mon_j%0d", j), int'(mon),
             int'((j >= 1 && j <= 4) || (j >= 7 && j <= 10)));
      lcheck($sformatf("t3_sol_j%0d", j), int'(sol), 0);
    end

    // Held levels give one event each; a re-raise queues another.
    b_sol = cnt_sol;
    b_mon = cnt_mon;
    expulsar = 1'b1;
    cambio = 2'b01;
    repeat (12) @(negedge clk);
    expulsar = 1'b0;
    @(negedge clk);
    expulsar = 1'b1;
    @(negedge clk);
    expulsar = 1'b0;
    cambio = 2'b00;
    wait_idle(200);
    lcheck("t4_prod_pulses", cnt_sol - b_sol, 2);
    lcheck("t4_coin_pulses", cnt_mon - b_mon, 1);

    // Saturation: 6 x three coins on alternating cycles.
    b_mon = cnt_mon;
    lcheck("t5_desb_before", int'(desb), 0);
    for (int i = 0; i < 12; i++) begin
      cambio = (i % 2 == 0) ? 2'b11 : 2'b00;
      @(negedge clk);
    end
    cambio = 2'b00;
    lcheck("t5_desb_set", int'(desb), 1);
    wait_idle(400);
    lcheck("t5_desb_sticky", int'(desb), 1);
    lcheck("t5_coin_pulses", cnt_mon - b_mon, 17);

    // Asynchronous reset on the 2nd cycle of a product pulse.
    expulsar = 1'b1;
    cambio = 2'b10;
    @(negedge clk);
    expulsar = 1'b0;
    cambio = 2'b00;
    @(negedge clk);
    @(posedge clk);
    #2;
    lcheck("t6_sol_before", int'(sol), 1);
    rst = 1'b0;
    #1;
    lcheck("t6_sol_async", int'(sol), 0);
    lcheck("t6_ocu_async", int'(ocu), 0);
    lcheck("t6_desb_async", int'(desb), 0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    b_sol = cnt_sol;
    b_mon = cnt_mon;
    repeat (10) @(negedge clk);
    lcheck("t6_quiet_sol", cnt_sol - b_sol, 0);
    lcheck("t6_quiet_mon", cnt_mon - b_mon, 0);
    lcheck("t6_quiet_ocu", int'(ocu), 0);
    rst = 1'b0;
    expulsar = 1'b1;
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    expulsar = 1'b0;
    wait_idle(100);
    lcheck("t6_release_pulse", cnt_sol - b_sol, 1);

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 5) == 0) expulsar = ~expulsar;
      if ($urandom_range(0, 7) == 0) cambio = 2'($urandom_range(0, 3));
      @(negedge clk);
    end
    expulsar = 1'b0;
    cambio = 2'b00;
    wait_idle(2000);

    $display("%0d/%0d checks passed", n_pass_m + n_pass_l, n_tot_m + n_tot_l);
    $finish;
  end

endmodule
